// File: rtl/exec_flags_stage.sv
// Execute-stage flag unit.
// Holds the NZCV flag register and resolves branch direction for each ALU transaction.
// Results are buffered in a 2-entry FIFO of {result, taken}.
// Optional feature: define EXEC_FLAGS_STALL_CNT_EN to build a saturating stall-cycle counter.
// Without the macro, stall_cnt is tied to zero.
module exec_flags_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] result,
  input  logic        negative,
  input  logic        zero,
  input  logic        overflow,
  input  logic        carry_out,
  input  logic        set_flags,
  input  logic [1:0]  br_type,
  input  logic [3:0]  cond,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic        out_taken,
  output logic [3:0]  flags_q,
  output logic [31:0] stall_cnt
);

  logic [63:0] res_q [2];
  logic [1:0]  taken_q;
  logic        rd_ptr_q;
  logic        wr_ptr_q;
  logic [1:0]  count_q;

  logic accept;
  logic pop;
  logic cond_met;
  logic taken;
  logic fn, fz, fc, fv;

  // Handshake is derived only from registered occupancy.
  assign in_ready   = (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign out_result = res_q[rd_ptr_q];
  assign out_taken  = taken_q[rd_ptr_q];

  assign accept = in_valid && in_ready && !flush;
  assign pop    = out_valid && out_ready && !flush;

  assign {fn, fz, fc, fv} = flags_q;

  // Condition evaluation uses the flags held before this transaction's own update.
  always_comb begin
    cond_met = 1'b0;
    unique case (cond)
      4'b0000: cond_met = fz;
      4'b0001: cond_met = !fz;
      4'b0010: cond_met = fc;
      4'b0011: cond_met = !fc;
      4'b0100: cond_met = fn;
      4'b0101: cond_met = !fn;
      4'b0110: cond_met = fv;
      4'b0111: cond_met = !fv;
      4'b1000: cond_met = fc && !fz;
      4'b1001: cond_met = !fc || fz;
      4'b1010: cond_met = (fn == fv);
      4'b1011: cond_met = (fn != fv);
      4'b1100: cond_met = !fz && (fn == fv);
      4'b1101: cond_met = fz || (fn != fv);
      default: cond_met = 1'b1;
    endcase
  end

  // Branch direction per branch type; CBZ tests this transaction's own zero flag.
  always_comb begin
    taken = 1'b0;
    unique case (br_type)
      2'b00: taken = 1'b0;
      2'b01: taken = 1'b1;
      2'b10: taken = cond_met;
      2'b11: taken = zero;
      default: taken = 1'b0;
    endcase
  end

  // FIFO storage, pointers and occupancy; flush empties, reset clears everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q[0] <= '0;
      res_q[1] <= '0;
      taken_q  <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (accept) begin
        res_q[wr_ptr_q]   <= result;
        taken_q[wr_ptr_q] <= taken;
        wr_ptr_q          <= !wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= !rd_ptr_q;
      end
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Flag register: loads {N,Z,C,V} only on an accepted transaction with set_flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (accept && set_flags) begin
      flags_q <= {negative, zero, carry_out, overflow};
    end
  end

`ifdef EXEC_FLAGS_STALL_CNT_EN
  logic [31:0] stall_q;

  // Counts cycles where upstream is held off; saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (in_valid && !in_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: doc/exec_flags_stage.md
EXEC_FLAGS_STAGE -- requirements
Module: exec_flags_stage

Interface
REQ-001 The block SHALL have exactly one clock and its reset SHALL be synchronous and active-high (clock and reset names per codebase).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream ALU transaction valid.
REQ-005 in_ready  output  1  stage can accept; registered, no combinational path from out_ready.
REQ-006 result  input  64  ALU result.
REQ-007 negative, zero, overflow, carry_out  input  1 each  ALU flags for this transaction.
REQ-008 set_flags  input  1  commit this transaction's flags to the flag register.
REQ-009 br_type  input  2  00 none, 01 B (unconditional), 10 B.cond, 11 CBZ.
REQ-010 cond  input  4  ARM condition code for B.cond.
REQ-011 flush  input  1  discard all buffered and incoming transactions.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream accepts head entry.
REQ-014 out_result  output  64  head entry result.
REQ-015 out_taken  output  1  head entry branch taken.
REQ-016 flags_q  output  4  flag register {N,Z,C,V}.
REQ-017 stall_cnt  output  32  stall-cycle counter (see Configuration).

Function
REQ-018 Accept: in_valid && in_ready && !flush; pop: out_valid && out_ready && !flush.
REQ-019 Buffer SHALL be a 2-entry FIFO of {result, taken}; in_ready = (count < 2), computed from registered count.
REQ-020 Latency: transaction accepted in cycle N SHALL appear on out_* in cycle N+1 when buffer empty.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and preserve order.
REQ-022 Full buffer (count 2): in_ready low; input ignored even if in_valid high.
REQ-023 out_* SHALL hold stable while out_valid && !out_ready.
REQ-024 On accept with set_flags=1, flags_q SHALL load {negative,zero,carry_out,overflow} at the next edge; no update otherwise.
REQ-025 B.cond SHALL evaluate against flags_q as held in the accept cycle (previous flags, not the same transaction's flags).
REQ-026 Back-to-back: a transaction accepted in cycle N+1 SHALL see flags set by a transaction accepted in cycle N.
REQ-027 Conditions: 0000 EQ Z; 0001 NE !Z; 0010 HS C; 0011 LO !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110/1111 always.
REQ-028 taken: br_type 00 -> 0; 01 -> 1; 10 -> cond result; 11 -> zero input of the same transaction.
REQ-029 flush SHALL empty the FIFO at the next edge, block that cycle's accept and flag update, and leave flags_q otherwise unchanged.
REQ-030 flush SHALL take priority over accept, pop and in_valid in the same cycle.

Reset
REQ-031 reset SHALL set count=0, out_valid=0, out_result=0, out_taken=0, flags_q=0000, stall_cnt=0, in_ready=1 after the edge.
REQ-032 reset mid-operation SHALL discard buffered entries and SHALL take priority over flush, accept and pop.

Configuration
REQ-033 With macro EXEC_FLAGS_STALL_CNT_EN defined, stall_cnt SHALL increment each cycle with in_valid && !in_ready and saturate at 0xFFFFFFFF.
REQ-034 Without EXEC_FLAGS_STALL_CNT_EN, stall_cnt SHALL be constant 0, the port SHALL remain, and no counter SHALL be built.

Verification
REQ-035 Reset, then accept result=64'd20000, br_type=00, out_ready=1 -> next cycle out_valid=1, out_result=20000, out_taken=0, flags_q=0000.
REQ-036 Accept SUBS-like txn zero=1,set_flags=1, then B.cond cond=0000 back-to-back -> flags_q=0100, second entry out_taken=1; cond=0001 -> out_taken=0.
REQ-037 out_ready=0, three consecutive in_valid -> first two accepted, in_ready=0 from third cycle, stall_cnt increments (macro on) or stays 0 (macro off); release out_ready -> entries drain in order.
REQ-038 Two entries buffered, flush=1 with in_valid=1 -> next cycle out_valid=0, count 0, flags_q unchanged.
REQ-039 CBZ with zero=1, then zero=0; set flags N=1,V=0 and test cond=1010/1011 -> out_taken 1,0,0,1.
